// File: rtl/rv_pkg.sv
// Shared encodings for the instruction/data memory arbiter: FSM states and port owner.
// Latency: none, constants only.
// Backpressure: none, constants only.
package rv_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/rv_mem_arb.sv
// Arbitrates fetch and data requesters onto one single-outstanding memory port.
// Latency: mem_req_o one cycle after request is sampled; gnt with mem_gnt_i; rvalid passes through from mem_rvalid_i.
// Backpressure: requesters hold req until their gnt pulse; memory stalls by withholding mem_gnt_i.
module rv_mem_arb
   import rv_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rstn,
   // fetch port
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_gnt_o,
   output logic                if_rvalid_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   // data port
   input  logic                dm_req_i,
   input  logic                dm_we_i,
   input  logic [DATA_W/8-1:0] dm_be_i,
   input  logic [ADDR_W-1:0]   dm_addr_i,
   input  logic [DATA_W-1:0]   dm_wdata_i,
   output logic                dm_gnt_o,
   output logic                dm_rvalid_o,
   output logic [DATA_W-1:0]   dm_rdata_o,
   // shared memory port
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i
);

   localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [1:0]       state;
   logic             owner;
   logic [CNT_W-1:0] starve_cnt;
   logic             fetch_wins;
   logic             mem_take;
   logic             resp_phase;

   // Data normally has priority; a waiting fetch gets through once it has been passed over STARVE_MAX times.
   assign fetch_wins = if_req_i && (!dm_req_i || (starve_cnt == STARVE_LIM));

   // Memory accept only counts while a request is actually being presented.
   assign mem_take   = (state == ST_REQ) && mem_gnt_i;
   assign resp_phase = (state == ST_RESP);

   assign if_gnt_o    = mem_take && (owner == OWN_IF);
   assign dm_gnt_o    = mem_take && (owner == OWN_DM);
   assign if_rvalid_o = resp_phase && mem_rvalid_i && (owner == OWN_IF);
   assign dm_rvalid_o = resp_phase && mem_rvalid_i && (owner == OWN_DM);
   assign if_rdata_o  = (resp_phase && (owner == OWN_IF)) ? mem_rdata_i : '0;
   assign dm_rdata_o  = (resp_phase && (owner == OWN_DM)) ? mem_rdata_i : '0;

   // Transaction FSM: latch the winner onto the registered memory port, hold until accepted, wait for response.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         owner       <= OWN_IF;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_be_o    <= '0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (if_req_i || dm_req_i) begin
                  state     <= ST_REQ;
                  mem_req_o <= 1'b1;
                  if (fetch_wins) begin
                     owner       <= OWN_IF;
                     mem_we_o    <= 1'b0;
                     mem_be_o    <= '1;
                     mem_addr_o  <= if_addr_i;
                     mem_wdata_o <= '0;
                  end else begin
                     owner       <= OWN_DM;
                     mem_we_o    <= dm_we_i;
                     mem_be_o    <= dm_be_i;
                     mem_addr_o  <= dm_addr_i;
                     mem_wdata_o <= dm_wdata_i;
                  end
               end
            end
            ST_REQ: begin
               if (mem_gnt_i) begin
                  state     <= ST_RESP;
                  mem_req_o <= 1'b0;
               end
            end
            ST_RESP: begin
               if (mem_rvalid_i) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               mem_req_o <= 1'b0;
            end
         endcase
      end
   end

   // Count data grants that overtook a waiting fetch; any fetch grant or an idle fetch port clears it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         starve_cnt <= '0;
      end else if (!if_req_i || if_gnt_o) begin
         starve_cnt <= '0;
      end else if (dm_gnt_o && (starve_cnt != STARVE_LIM)) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Scoreboarded bench for rv_mem_arb: requester drivers, a memory responder model and a response monitor.
// Latency: expected responses are queued at grant and popped on rvalid.
// Backpressure: the responder can stall grants and hold back responses on demand.
module tb_rv_mem_arb;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SM = 4;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dreq_t;

   logic          clk;
   logic          rstn;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_gnt_o;
   logic          if_rvalid_o;
   logic [DW-1:0] if_rdata_o;
   logic          dm_req_i;
   logic          dm_we_i;
   logic [3:0]    dm_be_i;
   logic [AW-1:0] dm_addr_i;
   logic [DW-1:0] dm_wdata_i;
   logic          dm_gnt_o;
   logic          dm_rvalid_o;
   logic [DW-1:0] dm_rdata_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [3:0]    mem_be_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_gnt_i;
   logic          mem_rvalid_i;
   logic [DW-1:0] mem_rdata_i;

   rv_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rstn(rstn),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
      .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] if_stim[$];
   dreq_t       dm_stim[$];
   logic [31:0] if_exp[$];
   logic [32:0] dm_exp[$];
   byte         gnt_log[$];
   int          gnt_cyc[$];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] phys_mem[logic [31:0]];

   bit          if_gnt_q    = 1'b0;
   bit          dm_gnt_q    = 1'b0;
   int          stall_cnt   = 0;
   bit          rsp_hold    = 1'b0;
   bit          rsp_pending = 1'b0;
   bit          inject_rv   = 1'b0;
   logic [31:0] rsp_data    = '0;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic logic [31:0] phys_rd(input logic [31:0] a);
      return phys_mem.exists(a) ? phys_mem[a] : dflt(a);
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Fetch requester: holds req/addr until granted, queues the expected read data at grant.
   initial begin
      logic [31:0] a;
      if_req_i  = 1'b0;
      if_addr_i = '0;
      forever begin
         @(posedge clk); #1;
         if (if_gnt_q) begin
            if_gnt_q = 1'b0;
            if (if_stim.size() > 0) begin
               a = if_stim.pop_front();
               if_exp.push_back(ref_rd(a));
            end
         end
         if (if_stim.size() > 0) begin
            if_req_i  = 1'b1;
            if_addr_i = if_stim[0];
         end else begin
            if_req_i  = 1'b0;
         end
      end
   end

   // Data requester: same handshake, updates the reference memory on write grants.
   initial begin
      dreq_t r;
      dm_req_i   = 1'b0;
      dm_we_i    = 1'b0;
      dm_be_i    = '0;
      dm_addr_i  = '0;
      dm_wdata_i = '0;
      forever begin
         @(posedge clk); #1;
         if (dm_gnt_q) begin
            dm_gnt_q = 1'b0;
            if (dm_stim.size() > 0) begin
               r = dm_stim.pop_front();
               if (r.we) begin
                  ref_mem[r.addr] = merge(ref_rd(r.addr), r.wdata, r.be);
                  dm_exp.push_back({1'b1, 32'h0});
               end else begin
                  dm_exp.push_back({1'b0, ref_rd(r.addr)});
               end
            end
         end
         if (dm_stim.size() > 0) begin
            r          = dm_stim[0];
            dm_req_i   = 1'b1;
            dm_we_i    = r.we;
            dm_be_i    = r.be;
            dm_addr_i  = r.addr;
            dm_wdata_i = r.wdata;
         end else begin
            dm_req_i   = 1'b0;
            dm_we_i    = 1'b0;
         end
      end
   end

   // Memory model: optional grant stall, response one cycle after grant unless held back.
   initial begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      forever begin
         @(posedge clk); #1;
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         if (inject_rv) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hBAD0_0BAD;
            inject_rv    = 1'b0;
         end else if (rsp_pending && !rsp_hold) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rsp_data;
            rsp_pending  = 1'b0;
         end
         if (mem_req_o && !rsp_pending) begin
            if (stall_cnt > 0) begin
               stall_cnt--;
            end else begin
               mem_gnt_i   = 1'b1;
               rsp_pending = 1'b1;
               if (mem_we_o) begin
                  phys_mem[mem_addr_o] = merge(phys_rd(mem_addr_o), mem_wdata_o, mem_be_o);
                  rsp_data = 32'h0;
               end else begin
                  rsp_data = phys_rd(mem_addr_o);
               end
            end
         end
      end
   end

   // Monitor: checks the bus against the granted request and responses against the scoreboard.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (if_gnt_o) begin
               if_gnt_q = 1'b1;
               gnt_log.push_back("I");
               gnt_cyc.push_back(cyc);
               checks++;
               if (if_stim.size() == 0 || mem_addr_o !== if_stim[0] || mem_we_o !== 1'b0) begin
                  errors++;
                  $display("FAIL if_bus: addr %h we %b, expected fetch of queued address", mem_addr_o, mem_we_o);
               end
            end
            if (dm_gnt_o) begin
               dm_gnt_q = 1'b1;
               gnt_log.push_back("D");
               gnt_cyc.push_back(cyc);
               checks++;
               if (dm_stim.size() == 0 || mem_addr_o !== dm_stim[0].addr || mem_we_o !== dm_stim[0].we ||
                   mem_be_o !== dm_stim[0].be || (dm_stim[0].we && mem_wdata_o !== dm_stim[0].wdata)) begin
                  errors++;
                  $display("FAIL dm_bus: addr %h we %b be %h wdata %h differ from queued data request",
                           mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
               end
            end
            checks++;
            if (if_gnt_o && dm_gnt_o) begin
               errors++;
               $display("FAIL dual_gnt: both grants high, expected at most one");
            end
            checks++;
            if (if_rvalid_o && dm_rvalid_o) begin
               errors++;
               $display("FAIL dual_rvalid: both rvalid high, expected at most one");
            end
            if (if_rvalid_o) begin
               checks++;
               if (if_exp.size() == 0) begin
                  errors++;
                  $display("FAIL if_unexpected: if_rvalid_o with no outstanding fetch, data %h", if_rdata_o);
               end else begin
                  e[31:0] = if_exp.pop_front();
                  if (if_rdata_o !== e[31:0]) begin
                     errors++;
                     $display("FAIL if_rdata: got %h expected %h", if_rdata_o, e[31:0]);
                  end
               end
            end
            if (dm_rvalid_o) begin
               checks++;
               if (dm_exp.size() == 0) begin
                  errors++;
                  $display("FAIL dm_unexpected: dm_rvalid_o with no outstanding data request, data %h", dm_rdata_o);
               end else begin
                  e = dm_exp.pop_front();
                  if (!e[32] && dm_rdata_o !== e[31:0]) begin
                     errors++;
                     $display("FAIL dm_rdata: got %h expected %h", dm_rdata_o, e[31:0]);
                  end
               end
            end
            if (dm_rvalid_o && !if_rvalid_o) begin
               checks++;
               if (if_rdata_o !== '0) begin
                  errors++;
                  $display("FAIL if_rdata_nonowner: got %h expected 0", if_rdata_o);
               end
            end
            if (if_rvalid_o && !dm_rvalid_o) begin
               checks++;
               if (dm_rdata_o !== '0) begin
                  errors++;
                  $display("FAIL dm_rdata_nonowner: got %h expected 0", dm_rdata_o);
               end
            end
         end
      end
   end

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((if_stim.size() > 0 || dm_stim.size() > 0 || if_exp.size() > 0 || dm_exp.size() > 0 ||
              rsp_pending || mem_req_o) && n < 600) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (n >= 600) begin
         errors++;
         $display("FAIL %s_timeout: traffic still pending after %0d cycles, expected drain", tag, n);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b1;
      #2 rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o,
           if_rdata_o, dm_rdata_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: req %b addr %h be %h gnt %b/%b rvalid %b/%b, expected all 0",
                  mem_req_o, mem_addr_o, mem_be_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o);
      end
      rstn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_fetch_latency();
      int n;
      if_stim.push_back(32'h100);
      n = 0;
      while (!if_req_i && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (mem_req_o !== 1'b0 || if_gnt_o !== 1'b0) begin
         errors++;
         $display("FAIL lat_c0: mem_req_o %b if_gnt_o %b, expected 0 0", mem_req_o, if_gnt_o);
      end
      @(negedge clk);
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || if_gnt_o !== 1'b1 || dm_gnt_o !== 1'b0) begin
         errors++;
         $display("FAIL lat_c1: req %b addr %h if_gnt %b dm_gnt %b, expected 1 00000100 1 0",
                  mem_req_o, mem_addr_o, if_gnt_o, dm_gnt_o);
      end
      @(negedge clk);
      checks++;
      if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hC0DE_0100 || mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL lat_c2: rvalid %b rdata %h req %b, expected 1 c0de0100 0", if_rvalid_o, if_rdata_o, mem_req_o);
      end
      wait_idle("fetch_latency");
   endtask

   task automatic test_arb_simul();
      gnt_log.delete();
      dm_stim.push_back(dreq_t'{1'b1, 4'hF, 32'h2000, 32'hCAFE_F00D});
      if_stim.push_back(32'h104);
      wait_idle("arb_simul");
      checks++;
      if (gnt_log.size() != 2 || gnt_log[0] != "D" || gnt_log[1] != "I") begin
         errors++;
         $display("FAIL arb_order: %0d grants, first %c, expected 2 grants D then I", gnt_log.size(),
                  gnt_log.size() > 0 ? gnt_log[0] : 8'h3F);
      end
   endtask

   task automatic test_write_read();
      int n;
      int seen;
      dm_stim.push_back(dreq_t'{1'b1, 4'b0101, 32'h2000, 32'h1122_3344});
      dm_stim.push_back(dreq_t'{1'b0, 4'hF, 32'h2000, 32'h0});
      n = 0;
      seen = 0;
      while (seen < 2 && n < 100) begin
         @(negedge clk);
         n++;
         if (dm_rvalid_o) begin
            seen++;
            if (seen == 2) begin
               checks++;
               if (dm_rdata_o !== 32'hCA22_F044) begin
                  errors++;
                  $display("FAIL partial_write: read %h expected ca22f044", dm_rdata_o);
               end
            end
         end
      end
      checks++;
      if (seen != 2) begin
         errors++;
         $display("FAIL write_read_timeout: %0d responses seen, expected 2", seen);
      end
      wait_idle("write_read");
   endtask

   task automatic test_starve();
      string exp_s;
      exp_s = "DDDDIDDDDIDDI";
      gnt_log.delete();
      for (int i = 0; i < 10; i++) dm_stim.push_back(dreq_t'{1'b0, 4'hF, 32'h3000 + 32'(4 * i), 32'h0});
      for (int i = 0; i < 3; i++) if_stim.push_back(32'h400 + 32'(4 * i));
      wait_idle("starve");
      checks++;
      if (gnt_log.size() != exp_s.len()) begin
         errors++;
         $display("FAIL starve_count: %0d grants expected %0d", gnt_log.size(), exp_s.len());
      end
      for (int i = 0; i < exp_s.len() && i < gnt_log.size(); i++) begin
         checks++;
         if (gnt_log[i] != exp_s[i]) begin
            errors++;
            $display("FAIL starve_order[%0d]: got %c expected %c", i, gnt_log[i], exp_s[i]);
         end
      end
   endtask

   task automatic test_stall();
      int n;
      stall_cnt = 5;
      dm_stim.push_back(dreq_t'{1'b0, 4'hF, 32'h5000, 32'h0});
      n = 0;
      while (!mem_req_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h5000 || mem_we_o !== 1'b0 || dm_gnt_o !== 1'b0 ||
             if_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: req %b addr %h we %b gnt %b, expected 1 00005000 0 0",
                     i, mem_req_o, mem_addr_o, mem_we_o, dm_gnt_o);
         end
         @(negedge clk);
      end
      checks++;
      if (dm_gnt_o !== 1'b1 || mem_addr_o !== 32'h5000) begin
         errors++;
         $display("FAIL stall_release: dm_gnt_o %b addr %h, expected 1 00005000", dm_gnt_o, mem_addr_o);
      end
      wait_idle("stall");
   endtask

   task automatic test_back_to_back();
      gnt_cyc.delete();
      for (int i = 0; i < 4; i++) if_stim.push_back(32'h800 + 32'(4 * i));
      wait_idle("back_to_back");
      checks++;
      if (gnt_cyc.size() != 4) begin
         errors++;
         $display("FAIL b2b_count: %0d grants expected 4", gnt_cyc.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (gnt_cyc[i+1] - gnt_cyc[i] != 3) begin
               errors++;
               $display("FAIL b2b_spacing[%0d]: %0d cycles between grants expected 3", i, gnt_cyc[i+1] - gnt_cyc[i]);
            end
         end
      end
   endtask

   task automatic test_spurious();
      inject_rv = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (if_rvalid_o !== 1'b0 || dm_rvalid_o !== 1'b0 || if_rdata_o !== '0 || dm_rdata_o !== '0) begin
            errors++;
            $display("FAIL spurious_rvalid: rvalid %b/%b rdata %h/%h, expected all 0",
                     if_rvalid_o, dm_rvalid_o, if_rdata_o, dm_rdata_o);
         end
      end
      wait_idle("spurious");
   endtask

   task automatic test_reset_mid_resp();
      int n;
      rsp_hold = 1'b1;
      if_stim.push_back(32'h300);
      n = 0;
      while (!if_gnt_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (mem_req_o !== 1'b0 || if_rvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL resp_wait: req %b rvalid %b, expected 0 0", mem_req_o, if_rvalid_o);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, if_gnt_o, dm_gnt_o, if_rvalid_o,
           dm_rvalid_o} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: req %b addr %h be %h, expected all 0", mem_req_o, mem_addr_o, mem_be_o);
      end
      #1 rstn = 1'b1;
      if_exp.delete();
      rsp_hold = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (if_rvalid_o !== 1'b0 || dm_rvalid_o !== 1'b0 || mem_req_o !== 1'b0 || if_rdata_o !== '0) begin
            errors++;
            $display("FAIL late_rvalid[%0d]: rvalid %b/%b req %b rdata %h, expected all 0",
                     i, if_rvalid_o, dm_rvalid_o, mem_req_o, if_rdata_o);
         end
      end
      gnt_cyc.delete();
      if_stim.push_back(32'h304);
      wait_idle("after_reset");
      checks++;
      if (gnt_cyc.size() != 1) begin
         errors++;
         $display("FAIL after_reset_gnt: %0d grants expected 1", gnt_cyc.size());
      end
   endtask

   initial begin
      rstn = 1'b1;
      test_reset();
      test_fetch_latency();
      test_arb_simul();
      test_write_read();
      test_starve();
      test_stall();
      test_back_to_back();
      test_spurious();
      test_reset_mid_resp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_mem_arb.md
RV_MEM_ARB -- requirements
Module: rv_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive data grants allowed while fetch waits.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 if_req_i  input  1  fetch request; held with if_addr_i stable until if_gnt_o.
REQ-007 if_addr_i  input  ADDR_W  fetch address.
REQ-008 if_gnt_o  output  1  fetch request accepted by memory (1-cycle pulse).
REQ-009 if_rvalid_o / if_rdata_o  output  1 / DATA_W  fetch response.
REQ-010 dm_req_i, dm_we_i  input  1 each  data request, write enable; held stable with all dm_* until dm_gnt_o.
REQ-011 dm_be_i / dm_addr_i / dm_wdata_i  input  DATA_W/8 / ADDR_W / DATA_W  byte enables, address, write data.
REQ-012 dm_gnt_o  output  1  data request accepted (1-cycle pulse).
REQ-013 dm_rvalid_o / dm_rdata_o  output  1 / DATA_W  data response (read data or write ack).
REQ-014 mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  output  1,1,DATA_W/8,ADDR_W,DATA_W  shared memory port, all registered.
REQ-015 mem_gnt_i, mem_rvalid_i  input  1 each  memory accept, memory response valid.
REQ-016 mem_rdata_i  input  DATA_W  memory read data.

Function
REQ-017 SHALL implement FSM IDLE, REQ, RESP; exactly one transaction outstanding.
REQ-018 IDLE: no request -> stay; any request -> REQ next cycle, owner and mem_* latched from winner, mem_req_o=1.
REQ-019 Arbitration: data wins over fetch, except fetch wins when starve count equals STARVE_MAX and if_req_i=1.
REQ-020 Starve count: +1 on each data grant while if_req_i=1; cleared on fetch grant or when if_req_i=0; saturates at STARVE_MAX.
REQ-021 REQ: mem_req_o and mem_* held constant until mem_gnt_i=1; that cycle owner's gnt_o=1, mem_req_o=0 next cycle, -> RESP.
REQ-022 RESP: owner's rvalid_o = mem_rvalid_i, rdata_o = mem_rdata_i combinationally; on mem_rvalid_i -> IDLE.
REQ-023 Minimum latency: request sampled cycle 0, mem_req_o cycle 1, gnt cycle 1 if mem_gnt_i=1, rvalid earliest cycle 2.
REQ-024 Back-to-back: one IDLE cycle between transactions; pending requester arbitrated in that IDLE cycle.
REQ-025 Non-owner rvalid_o SHALL be 0; rdata_o of non-owner SHALL be 0.
REQ-026 mem_rvalid_i in IDLE or REQ SHALL be ignored; mem_gnt_i outside REQ SHALL be ignored.
REQ-027 Requester deasserting req before gnt is illegal; behaviour then unspecified but FSM SHALL not lock up (completes memory transaction).
REQ-028 Writes SHALL complete with rvalid_o pulse; rdata_o value on write ack don't-care.

Reset
REQ-029 rstn low SHALL force state IDLE, starve count 0, owner fetch, all mem_* outputs 0, all gnt/rvalid outputs 0.
REQ-030 Reset mid-transaction SHALL abandon it; a late mem_rvalid_i after release SHALL be ignored (arrives in IDLE).

Structure
REQ-031 State encoding, owner encoding (OWN_IF, OWN_DM) SHALL live in shared package rv_pkg.
REQ-032 Single module; starve counter inline, no sub-module.

Verification
REQ-033 Fetch only, mem_gnt_i=1, rvalid 1 cycle later, addr 0x100 -> mem_addr_o=0x100 cycle 1, if_gnt_o cycle 1, if_rvalid_o cycle 2 with rdata.
REQ-034 Simultaneous if_req/dm_req, dm store addr 0x2000 be 0xF -> data first, fetch granted next transaction.
REQ-035 Continuous dm_req and if_req, STARVE_MAX=4 -> 4 data grants then 1 fetch grant, repeating.
REQ-036 mem_gnt_i held low 5 cycles -> mem_* stable, no gnt_o until mem_gnt_i=1.
REQ-037 rstn pulsed during RESP, then mem_rvalid_i=1 -> no rvalid_o, state IDLE, outputs 0.
REQ-038 Spurious mem_rvalid_i in IDLE -> no rvalid_o on either port.
